// File: rtl/operand_fetch_sequencer_pkg.sv
// Shared state type, instruction field layout and field helpers for the operand fetch sequencer.
package operand_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssueA,
        StWaitA,
        StIssueB,
        StWaitB,
        StPresent,
        StFinish
    } seq_state_t;

    // Helpers take a zero-extended word so they work for any configured field widths.
    localparam int unsigned FIELD_MAX = 64;
    localparam logic [FIELD_MAX-1:0] OPC_HALT = '1;
    localparam int unsigned CODE_B_LSB = 0;

    function automatic int unsigned code_a_lsb(input int unsigned code_w);
        return code_w;
    endfunction

    function automatic int unsigned opc_lsb(input int unsigned code_w);
        return 2 * code_w;
    endfunction

    // Callers truncate the result to the field width.
    function automatic logic [FIELD_MAX-1:0] get_opc(input logic [FIELD_MAX-1:0] instr,
                                                     input int unsigned code_w);
        return instr >> opc_lsb(code_w);
    endfunction

    function automatic logic [FIELD_MAX-1:0] get_code_a(input logic [FIELD_MAX-1:0] instr,
                                                        input int unsigned code_w);
        return instr >> code_a_lsb(code_w);
    endfunction

    function automatic logic [FIELD_MAX-1:0] get_code_b(input logic [FIELD_MAX-1:0] instr);
        return instr >> CODE_B_LSB;
    endfunction

endpackage

// File: rtl/operand_fetch_sequencer_if.sv
// Decoder request/response and datapath operand-bundle handshake of the fetch sequencer.
interface operand_fetch_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CODE_WIDTH = 7,
    parameter int unsigned OPC_WIDTH  = 4
);
    logic                  decode_start;
    logic [CODE_WIDTH-1:0] dec_code;
    logic                  dec_data_ready;
    logic [DATA_WIDTH-1:0] dec_value;
    logic                  op_valid;
    logic                  op_ready;
    logic [OPC_WIDTH-1:0]  op_opcode;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    modport master (
        output decode_start, dec_code, op_valid, op_opcode, op_a, op_b,
        input  dec_data_ready, dec_value, op_ready
    );

    modport slave (
        input  decode_start, dec_code, op_valid, op_opcode, op_a, op_b,
        output dec_data_ready, dec_value, op_ready
    );
endinterface

// File: rtl/operand_fetch_sequencer_delay_counter.sv
// Loadable down-counter with a zero flag, used to time fixed-latency memory reads.
module operand_fetch_sequencer_delay_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (decrement && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/operand_fetch_sequencer.sv
// Fetches instruction words, resolves both operand codes through the decoder and presents
// {opcode, A, B} to the datapath until a HALT opcode or the last program address.
module operand_fetch_sequencer
    import operand_fetch_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CODE_WIDTH = 7,
    parameter int unsigned OPC_WIDTH  = 4,
    parameter int unsigned NUM_INSTR  = 64,
    parameter int unsigned MEM_DELAY  = 2,
    localparam int unsigned INSTR_WIDTH = OPC_WIDTH + 2 * CODE_WIDTH,
    localparam int unsigned PCW         = $clog2(NUM_INSTR)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [PCW-1:0]           prog_addr,
    input  logic [INSTR_WIDTH-1:0]   prog_data,
    operand_fetch_sequencer_if.master bus,
    output logic                     busy,
    output logic                     done,
    output logic [PCW:0]             instr_count
);
    localparam int unsigned CNT_W = $clog2(MEM_DELAY + 1);

    seq_state_t            state_q;
    logic                  fetch_armed_q;
    logic [OPC_WIDTH-1:0]  opc_q;
    logic [CODE_WIDTH-1:0] code_b_q;
    logic [OPC_WIDTH-1:0]  fetch_opc;
    logic [CODE_WIDTH-1:0] fetch_code_a;
    logic [CODE_WIDTH-1:0] fetch_code_b;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  last_instr;

    assign fetch_opc    = OPC_WIDTH'(get_opc(FIELD_MAX'(prog_data), CODE_WIDTH));
    assign fetch_code_a = CODE_WIDTH'(get_code_a(FIELD_MAX'(prog_data), CODE_WIDTH));
    assign fetch_code_b = CODE_WIDTH'(get_code_b(FIELD_MAX'(prog_data)));

    // The first FETCH cycle arms the counter, so the word is sampled MEM_DELAY+1 cycles in.
    assign cnt_load = (state_q == StFetch) && !fetch_armed_q;
    assign cnt_dec  = (state_q == StFetch) && fetch_armed_q;

    assign last_instr = (bus.op_opcode == OPC_WIDTH'(OPC_HALT)) ||
                        (prog_addr == PCW'(NUM_INSTR - 1));

    operand_fetch_sequencer_delay_counter #(
        .WIDTH (CNT_W)
    ) u_fetch_delay (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (CNT_W'(MEM_DELAY - 1)),
        .decrement  (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            fetch_armed_q    <= 1'b0;
            opc_q            <= '0;
            code_b_q         <= '0;
            prog_addr        <= '0;
            bus.decode_start <= 1'b0;
            bus.dec_code     <= '0;
            bus.op_valid     <= 1'b0;
            bus.op_opcode    <= '0;
            bus.op_a         <= '0;
            bus.op_b         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            instr_count      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        prog_addr   <= '0;
                        instr_count <= '0;
                        busy        <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
                StFetch: begin
                    if (!fetch_armed_q) begin
                        fetch_armed_q <= 1'b1;
                    end else if (cnt_zero) begin
                        fetch_armed_q    <= 1'b0;
                        opc_q            <= fetch_opc;
                        code_b_q         <= fetch_code_b;
                        bus.dec_code     <= fetch_code_a;
                        bus.decode_start <= 1'b1;
                        state_q          <= StIssueA;
                    end
                end
                StIssueA: begin
                    bus.decode_start <= 1'b0;
                    state_q          <= StWaitA;
                end
                StWaitA: begin
                    if (bus.dec_data_ready) begin
                        bus.op_a         <= bus.dec_value;
                        bus.dec_code     <= code_b_q;
                        bus.decode_start <= 1'b1;
                        state_q          <= StIssueB;
                    end
                end
                StIssueB: begin
                    bus.decode_start <= 1'b0;
                    state_q          <= StWaitB;
                end
                StWaitB: begin
                    if (bus.dec_data_ready) begin
                        bus.op_b      <= bus.dec_value;
                        bus.op_opcode <= opc_q;
                        bus.op_valid  <= 1'b1;
                        state_q       <= StPresent;
                    end
                end
                StPresent: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        instr_count  <= instr_count + 1'b1;
                        if (last_instr) begin
                            done    <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            prog_addr <= prog_addr + 1'b1;
                            state_q   <= StFetch;
                        end
                    end
                end
                StFinish: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed-random bench: ROM and decoder models drive the sequencer, a queue model predicts bundles.
module tb_operand_fetch_sequencer;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 7;
    localparam int unsigned OW  = 4;
    localparam int unsigned NI  = 4;
    localparam int unsigned MD  = 2;
    localparam int unsigned IW  = OW + 2 * CW;
    localparam int unsigned PCW = $clog2(NI);

    typedef struct packed {
        logic [OW-1:0] opc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } bundle_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [PCW-1:0] prog_addr;
    logic [IW-1:0]  prog_data;
    logic           busy;
    logic           done;
    logic [PCW:0]   instr_count;

    logic [IW-1:0]  rom [NI];
    logic [IW-1:0]  rom_pipe [MD];

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    bundle_t       exp_q[$];
    logic [CW-1:0] exp_codes[$];

    int            dec_lat = 1;
    bit            stray_en = 1'b0;
    int            dec_cnt;
    logic          dec_pending;
    logic [CW-1:0] held_code;
    logic [CW-1:0] want_code;

    operand_fetch_sequencer_if #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .OPC_WIDTH(OW)) bus ();

    operand_fetch_sequencer #(
        .DATA_WIDTH (DW),
        .CODE_WIDTH (CW),
        .OPC_WIDTH  (OW),
        .NUM_INSTR  (NI),
        .MEM_DELAY  (MD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Program ROM: MD register stages behind the address.
    always @(posedge clock) begin
        rom_pipe[0] <= rom[prog_addr];
        for (int i = 1; i < MD; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign prog_data = rom_pipe[MD-1];

    function automatic logic [DW-1:0] dec_fn(input logic [CW-1:0] c);
        if (c == 7'h05) return 32'h11;
        if (c == 7'h45) return 32'h22;
        return 32'hA500_0000 + 32'(c) * 32'h0001_0101;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input int halt_at);
        for (int i = 0; i < NI; i++)
            rom[i] = {4'($urandom_range(0, 14)), 7'($urandom_range(0, 127)),
                      7'($urandom_range(0, 127))};
        if (halt_at >= 0) rom[halt_at][IW-1 -: OW] = '1;
    endtask

    // Reference: walk the program, stop after HALT or the last address.
    task automatic build_model();
        logic [OW-1:0] opc;
        logic [CW-1:0] ca;
        logic [CW-1:0] cb;
        exp_q.delete();
        exp_codes.delete();
        for (int pc = 0; pc < NI; pc++) begin
            opc = rom[pc][IW-1 -: OW];
            ca  = rom[pc][2*CW-1 -: CW];
            cb  = rom[pc][CW-1:0];
            exp_codes.push_back(ca);
            exp_codes.push_back(cb);
            exp_q.push_back({opc, dec_fn(ca), dec_fn(cb)});
            if (opc == 4'hF) break;
        end
    endtask

    // Decoder model: answers each decode_start after dec_lat cycles; optional stray pulses.
    initial begin
        bus.dec_data_ready = 1'b0;
        bus.dec_value = '0;
        dec_pending = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                dec_pending = 1'b0;
                bus.dec_data_ready = 1'b0;
            end else if (bus.decode_start) begin
                chk("issue_single_pulse", dec_pending, 0);
                if (exp_codes.size() > 0) want_code = exp_codes.pop_front();
                else want_code = 'x;
                chk("issue_code", bus.dec_code, want_code);
                held_code = bus.dec_code;
                dec_pending = 1'b1;
                dec_cnt = dec_lat;
                bus.dec_data_ready = 1'b0;
            end else if (dec_pending) begin
                chk("code_stable", bus.dec_code, held_code);
                dec_cnt--;
                if (dec_cnt == 0) begin
                    bus.dec_data_ready = 1'b1;
                    bus.dec_value = dec_fn(held_code);
                    dec_pending = 1'b0;
                end else begin
                    bus.dec_data_ready = 1'b0;
                end
            end else if (stray_en && busy && !done) begin
                bus.dec_data_ready = 1'b1;
                bus.dec_value = 32'hDEAD_BEEF;
            end else begin
                bus.dec_data_ready = 1'b0;
            end
        end
    end

    task automatic run_prog(input string tag, input int bp, input bit hold_start);
        int      got;
        bit      finished;
        bit      have;
        bundle_t want;
        got = 0;
        finished = 1'b0;
        have = 1'b0;
        build_model();
        @(negedge clock);
        start = 1'b1;
        if (!hold_start) begin
            @(negedge clock);
            start = 1'b0;
        end
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (!have) @(negedge clock);
            have = 1'b0;
            if (done) begin
                start = 1'b0;
                chk({tag, "_busy_in_finish"}, busy, 1);
                chk({tag, "_bundles"}, got, exp_q.size());
                chk({tag, "_instr_count"}, instr_count, exp_q.size());
                chk({tag, "_last_pc"}, prog_addr, exp_q.size() - 1);
                chk({tag, "_codes_left"}, exp_codes.size(), 0);
                @(negedge clock);
                chk({tag, "_done_one_cycle"}, done, 0);
                chk({tag, "_idle_busy"}, busy, 0);
                finished = 1'b1;
            end else if (bus.op_valid) begin
                want = (got < exp_q.size()) ? exp_q[got] : 'x;
                chk({tag, "_bundle"}, {bus.op_opcode, bus.op_a, bus.op_b}, want);
                for (int k = 0; k < bp; k++) begin
                    @(negedge clock);
                    chk({tag, "_held_valid"}, bus.op_valid, 1);
                    chk({tag, "_held_bundle"}, {bus.op_opcode, bus.op_a, bus.op_b}, want);
                end
                bus.op_ready = 1'b1;
                @(negedge clock);
                bus.op_ready = 1'b0;
                got++;
                chk({tag, "_valid_drop"}, bus.op_valid, 0);
                chk({tag, "_count_step"}, instr_count, got);
                have = 1'b1;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, finished, 1);
        // Idle afterwards: a held start must not have relaunched the run.
        repeat (4) @(negedge clock);
        chk({tag, "_stays_idle"}, busy, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.op_ready = 1'b0;
        fill_rom(-1);
        repeat (3) @(negedge clock);
        #3 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.op_valid, 0);
        chk("rst_decode_start", bus.decode_start, 0);
        chk("rst_prog_addr", prog_addr, 0);
        chk("rst_bundle", {bus.op_opcode, bus.op_a, bus.op_b}, 0);
        chk("rst_instr_count", instr_count, 0);

        // Single HALT instruction with the reference decoder values.
        fill_rom(-1);
        rom[0] = {4'hF, 7'h05, 7'h45};
        dec_lat = 1;
        run_prog("single", 0, 1'b0);

        // Backpressure on a three-instruction program.
        fill_rom(2);
        dec_lat = 1;
        run_prog("backpressure", 5, 1'b0);

        // No HALT: runs to the last address.
        fill_rom(-1);
        dec_lat = $urandom_range(1, 3);
        run_prog("run_to_end", 0, 1'b0);

        // Stray data_ready outside WAIT and start held high through the run.
        fill_rom(-1);
        dec_lat = 2;
        stray_en = 1'b1;
        run_prog("stray", 2, 1'b1);
        stray_en = 1'b0;

        // Slow decoder.
        fill_rom(1);
        dec_lat = 10;
        run_prog("slow_decoder", 0, 1'b0);

        // Reset while waiting on the decoder for operand A.
        fill_rom(-1);
        build_model();
        dec_lat = 50;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 20 && !bus.decode_start; i++) @(negedge clock);
        chk("midrun_issue_seen", bus.decode_start, 1);
        @(negedge clock);
        chk("midrun_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_valid", bus.op_valid, 0);
        chk("midrun_rst_decode_start", bus.decode_start, 0);
        chk("midrun_rst_dec_code", bus.dec_code, 0);
        chk("midrun_rst_prog_addr", prog_addr, 0);
        chk("midrun_rst_bundle", {bus.op_opcode, bus.op_a, bus.op_b}, 0);
        chk("midrun_rst_instr_count", instr_count, 0);
        exp_codes.delete();
        @(negedge clock);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("post_rst_no_issue", bus.decode_start, 0);
        end
        chk("post_rst_idle", busy, 0);

        // Clean run after the abort.
        fill_rom($urandom_range(0, NI - 1));
        dec_lat = $urandom_range(1, 4);
        run_prog("after_reset", $urandom_range(0, 3), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
